// File: rtl/addsub_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// addsub_sequencer_pkg
//   Shared definitions for the 4-bit add/subtract/multiply sequencer:
//   operand width, operation codes, controller state encoding and the
//   multiply iteration count.
// ---------------------------------------------------------------------------
package addsub_sequencer_pkg;

  localparam int WIDTH     = 4;
  localparam int RES_W     = 2 * WIDTH;
  localparam int MUL_ITERS = WIDTH;

  // Last value of the 2-bit iteration counter before the product is final.
  localparam logic [1:0] ITER_LAST = 2'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/addsub_sequencer_addsub4.sv
// ---------------------------------------------------------------------------
// addsub4
//   4-bit ripple-carry adder/subtractor.
//   m_i = 0 : s_o = a_i + b_i
//   m_i = 1 : s_o = a_i + ~b_i + 1   (a_i - b_i)
// Ports:
//   a_i, b_i  operands
//   m_i       mode; complements b_i and feeds the carry-in
//   s_o       sum/difference
//   cout_o    carry out of the top bit
//   v_o       signed overflow (carry into top bit XOR carry out)
// ---------------------------------------------------------------------------
module addsub4
  import addsub_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             m_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             v_o
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;

  assign bx = b_i ^ {WIDTH{m_i}};

  always_comb begin
    s_o  = '0;
    c    = '0;
    c[0] = m_i;
    for (int i = 0; i < WIDTH; i++) begin
      s_o[i]  = a_i[i] ^ bx[i] ^ c[i];
      c[i+1]  = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
    end
  end

  assign cout_o = c[WIDTH];
  assign v_o    = c[WIDTH-1] ^ c[WIDTH];

endmodule

// File: rtl/addsub_sequencer.sv
// ---------------------------------------------------------------------------
// addsub_sequencer
//   Sequencing controller for the shared 4-bit adder/subtractor. Accepts one
//   operation per start/busy/done handshake: single-cycle ADD/SUB, a
//   4-iteration shift-add unsigned multiply, or an illegal-op error report.
//
// Handshake: start is sampled only while idle (busy low); a start seen while
//   busy is dropped, never queued. busy is high from the cycle after the
//   accepting edge until the cycle after done. done is a one-cycle pulse and
//   result/cout/v/err are valid with it and held until the next operation
//   completes (err is cleared as soon as the next start is accepted).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        operation request
//   op           00 ADD, 01 SUB, 10 MUL, 11 illegal
//   a, b         operands, captured on the accepting edge
//   busy, done   handshake status
//   result       {4'b0, S} for ADD/SUB, full product for MUL
//   cout, v      adder carry-out / signed overflow for ADD/SUB, else 0
//   err          set with done for an illegal op
//   dbg_state    current controller state
// ---------------------------------------------------------------------------
module addsub_sequencer
  import addsub_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             cout,
  output logic             v,
  output logic             err,
  output state_e           dbg_state
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [1:0]       iter_q;
  logic             busy_q;
  logic             done_q;
  logic [RES_W-1:0] result_q;
  logic             cout_q;
  logic             v_q;
  logic             err_q;

  // Shared adder, muxed between EXEC (a, b, m=op[0]) and MUL (hi, mcand, m=0).
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_m;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic             add_v;

  always_comb begin
    add_a = a_q;
    add_b = b_q;
    add_m = op_q[0];
    if (state_q == ST_MUL) begin
      add_a = hi_q;
      add_b = a_q;    // a_q serves as the multiplicand
      add_m = 1'b0;
    end
  end

  addsub4 u_addsub4 (
    .a_i    (add_a),
    .b_i    (add_b),
    .m_i    (add_m),
    .s_o    (add_s),
    .cout_o (add_c),
    .v_o    (add_v)
  );

  // One shift-add step: conditionally add the multiplicand into the high
  // half, then shift the 9-bit {carry, hi, lo} right by one.
  logic             mul_c;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  always_comb begin
    if (lo_q[0]) begin
      mul_c   = add_c;
      mul_sum = add_s;
    end else begin
      mul_c   = 1'b0;
      mul_sum = hi_q;
    end
    hi_d = {mul_c, mul_sum[WIDTH-1:1]};
    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op_e'(op);
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (op == OP_MUL) begin
              hi_q    <= '0;
              lo_q    <= b;
              iter_q  <= '0;
              state_q <= ST_MUL;
            end else begin
              state_q <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          if (op_q == OP_ILL) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            v_q      <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            result_q <= {{WIDTH{1'b0}}, add_s};
            cout_q   <= add_c;
            v_q      <= add_v;
            err_q    <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end

        ST_MUL: begin
          hi_q   <= hi_d;
          lo_q   <= lo_d;
          iter_q <= iter_q + 2'd1;   // wraps back to 0 on the last step
          if (iter_q == ITER_LAST) begin
            result_q <= {hi_d, lo_d};
            cout_q   <= 1'b0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign v         = v_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/addsub_sequencer.md
# addsub_sequencer

Sequencing controller for the team's 4-bit adder/subtractor datapath. Accepts one operation at a time over a start/busy/done handshake and drives the shared adder for single-cycle ADD/SUB or a 4-iteration shift-add unsigned multiply. Results and flags are registered and held until the next accepted start. Sits between the front-panel/operation decoder and the arithmetic datapath.

## Interface
Parameters: none (4-bit operand width is fixed by the datapath).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB (a−b), 10 MUL (unsigned a×b), 11 illegal
- a  in  4  operand A, captured on accepted start
- b  in  4  operand B, captured on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  8  ADD/SUB: {4'b0, S}; MUL: full product
- cout  out  1  adder carry-out (ADD/SUB), else 0
- v  out  1  signed overflow, carry into bit 3 XOR carry-out (ADD/SUB), else 0
- err  out  1  high with done for op=11

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE: start=1 → capture a, b, op; op 00/01/11 → EXEC; op 10 → MUL with hi=0, lo=b, mcand=a, iter=0.
- EXEC: adder driven with a, b, m=op[0]; SUB is a + ~b + 1 (m feeds carry-in and complement). Register S→result[3:0], result[7:4]=0, cout, v; op 11 instead registers result=0, cout=v=0, err=1. → DONE.
- MUL: adder m=0, inputs hi and mcand. Per cycle: if lo[0], {c,hi'}=hi+mcand, else {c,hi'}={0,hi}; then {hi,lo}←{c,hi',lo}>>1. iter increments; after 4th iteration register result={hi,lo}, cout=v=err=0 → DONE.
- DONE: done=1 for this cycle only → IDLE.
- start while busy (including DONE) is ignored, not queued.
- result/cout/v/err hold until overwritten at the end of the next operation; err cleared on the next accepted start.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset: state IDLE; busy, done, result, cout, v, err, iter all 0. Reset mid-operation aborts with no done pulse.
- Edge k accepts start → busy high from cycle after edge k.
- ADD/SUB/illegal: result registered at edge k+1; done high cycle k+1→k+2.
- MUL: iterations at edges k+1..k+4; done high cycle k+4→k+5.
- Minimum spacing between accepted starts: 3 edges (ADD/SUB), 6 edges (MUL); earliest new start sampled on the edge leaving DONE+1 (i.e., in IDLE).
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package: op encodings (OP_ADD, OP_SUB, OP_MUL, OP_ILL), state encodings, width constant 4.
- One sub-module: addsub4 (4-bit ripple add/sub: a, b, m → S, cout, v), single instance, muxed between EXEC and MUL use. Controller logic lives in the top.

## Test plan
- Reset then idle: all outputs 0, busy 0 for 10 cycles with start=0.
- ADD a=7, b=1 → result 0x08, cout 0, v 1, done exactly 2 edges after accept.
- SUB a=3, b=5 → result 0x0E, cout 0, v 0; SUB a=5, b=3 → 0x02, cout 1, v 0.
- MUL a=15, b=15 → result 0xE1, cout 0, v 0, done 5 edges after accept; MUL a=0, b=9 → 0x00; MUL a=6, b=7 → 0x2A.
- start held high through a MUL with changing a/b → only one operation, result uses captured operands; op=11 → done with err 1, result 0.
- rst asserted at iteration 2 of MUL → immediate IDLE, outputs 0, no done; next ADD 2+2 → 0x04 correctly.
